// File: rtl/poly_eval_driver.sv
// Operand sequencer for the polynomial evaluator: sweeps x over num_points values,
// strobes A, B, C, x on go/data_out for each point and buffers the returned results.
module poly_eval_driver #(
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int RESULT_WAIT = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] coef_a,
  input  logic [7:0] coef_b,
  input  logic [7:0] coef_c,
  input  logic [7:0] x_start,
  input  logic [3:0] num_points,
  output logic       go,
  output logic [7:0] data_out,
  input  logic [7:0] data_result,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [3:0] point_count,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_DRIVE, S_GAP, S_WAIT, S_CAPTURE, S_DONE
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(RESULT_WAIT - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [1:0] idx;
  logic [3:0] pt_idx;
  logic [7:0] a_r, b_r, c_r, x_cur;
  logic [3:0] n_r;
  logic [7:0] operand;
  logic       more_pts;
  logic [7:0] mem [16];

  assign more_pts = ({1'b0, pt_idx} + 5'd1) < {1'b0, n_r};

  always_comb begin
    operand = a_r;
    case (idx)
      2'd0:    operand = a_r;
      2'd1:    operand = b_r;
      2'd2:    operand = c_r;
      default: operand = x_cur;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_LAUNCH;
      S_LAUNCH:  state_nxt = (n_r == 4'd0) ? S_DONE : S_DRIVE;
      S_DRIVE:   if (cnt == HOLD_LAST) state_nxt = S_GAP;
      S_GAP:     if (cnt == GAP_LAST) state_nxt = (idx == 2'd3) ? S_WAIT : S_DRIVE;
      S_WAIT:    if (cnt == WAIT_LAST) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = more_pts ? S_DRIVE : S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    go       = (state == S_DRIVE);
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    data_out = 8'd0;
    case (state)
      S_DRIVE, S_GAP:   data_out = operand;
      S_WAIT, S_CAPTURE: data_out = x_cur;
      default:          data_out = 8'd0;
    endcase
  end

  // Control: state, dwell counter, operand/point indices
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      idx         <= 2'd0;
      pt_idx      <= 4'd0;
      point_count <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt == state) ? cnt + 8'd1 : 8'd0;
      case (state)
        S_IDLE: if (start) point_count <= 4'd0;
        S_LAUNCH: begin
          idx    <= 2'd0;
          pt_idx <= 4'd0;
        end
        S_GAP: if (state_nxt == S_DRIVE) idx <= idx + 2'd1;
        S_CAPTURE: begin
          point_count <= point_count + 4'd1;
          if (more_pts) begin
            pt_idx <= pt_idx + 4'd1;
            idx    <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand latches; x_cur wraps naturally at 8 bits
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      a_r   <= coef_a;
      b_r   <= coef_b;
      c_r   <= coef_c;
      n_r   <= num_points;
      x_cur <= x_start;
    end else if (state == S_CAPTURE && more_pts) begin
      x_cur <= x_cur + 8'd1;
    end
  end

  // Result buffer survives reset; a capture coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (resetn && state == S_CAPTURE) mem[pt_idx] <= data_result;
  end

  always_ff @(posedge clk) begin
    if (!resetn) rd_data <= 8'd0;
    else         rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_poly_eval_driver.sv
// Directed bench for poly_eval_driver with a behavioural evaluator on go/data_in.
module tb_poly_eval_driver;

  logic       clk = 1'b0;
  logic       resetn, start;
  logic [7:0] coef_a, coef_b, coef_c, x_start;
  logic [3:0] num_points;
  logic       go;
  logic [7:0] data_out, data_result;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [3:0] point_count;
  logic       busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  poly_eval_driver dut (
    .clk(clk), .resetn(resetn), .start(start),
    .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c),
    .x_start(x_start), .num_points(num_points),
    .go(go), .data_out(data_out), .data_result(data_result),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .point_count(point_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Evaluator: shifts in one operand per go rising edge
  logic [7:0] ev_a = 0, ev_b = 0, ev_c = 0, ev_x = 0;
  logic       ev_go_q = 1'b0;
  always @(negedge clk) begin
    if (go && !ev_go_q) begin
      ev_a <= ev_b;
      ev_b <= ev_c;
      ev_c <= ev_x;
      ev_x <= data_out;
    end
    ev_go_q <= go;
  end
  assign data_result = 8'(ev_a * ev_x * ev_x + ev_b * ev_x + ev_c);

  // Strobe monitor
  logic [7:0] seq [64];
  int         lo_seq [64];
  int         go_rises = 0, hi_bad = 0, hi_len = 0, lo_len = 0;
  int         done_cnt = 0, launch_cyc = 0, done_cyc = 0;
  logic       go_q = 1'b0, busy_q = 1'b0;
  always @(negedge clk) begin
    if (go) begin
      if (!go_q) begin
        seq[go_rises[5:0]]    <= data_out;
        lo_seq[go_rises[5:0]] <= lo_len;
        go_rises <= go_rises + 1;
        hi_len   <= 1;
      end else begin
        hi_len <= hi_len + 1;
      end
    end else begin
      if (go_q && hi_len != 2) hi_bad <= hi_bad + 1;
      lo_len <= go_q ? 1 : lo_len + 1;
    end
    go_q <= go;
    if (busy && !busy_q) launch_cyc <= cyc;
    busy_q <= busy;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic launch(input logic [7:0] a, b, c, x, input logic [3:0] n);
    @(posedge clk); #1;
    coef_a = a; coef_b = b; coef_c = c; x_start = x; num_points = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    coef_a = 8'hA5; coef_b = 8'h5A; coef_c = 8'hC3; x_start = 8'h3C; num_points = 4'hF;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic read_buf(input logic [3:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic test_reset;
    int bad;
    resetn = 1'b0; start = 1'b0; rd_addr = 4'd0;
    coef_a = 0; coef_b = 0; coef_c = 0; x_start = 0; num_points = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (go !== 1'b0) begin n_fail++; $display("FAIL reset_go got %b want 0", go); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (point_count !== 4'd0) begin n_fail++; $display("FAIL reset_pc got %0d want 0", point_count); end
    n_checks++; if (data_out !== 8'd0) begin n_fail++; $display("FAIL reset_data got %0h want 0", data_out); end
    n_checks++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL reset_rd got %0h want 0", rd_data); end
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (go !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || data_out !== 8'd0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL idle_quiet got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_single;
    int base, hb, dc;
    bit ok;
    logic [7:0] d;
    logic [7:0] exp_ops [4] = '{8'd1, 8'd2, 8'd3, 8'd2};
    base = go_rises; hb = hi_bad; dc = done_cnt;
    launch(8'd1, 8'd2, 8'd3, 8'd2, 4'd1);
    wait_done(60, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_done got timeout want done"); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (go_rises - base != 4) begin n_fail++; $display("FAIL single_pulses got %0d want 4", go_rises - base); end
    n_checks++; if (hi_bad != hb) begin n_fail++; $display("FAIL single_hold got %0d bad want 0", hi_bad - hb); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (seq[(base + k) % 64] !== exp_ops[k]) begin
        n_fail++; $display("FAIL single_op%0d got %0d want %0d", k, seq[(base + k) % 64], exp_ops[k]);
      end
    end
    for (int k = 1; k < 4; k++) begin
      n_checks++;
      if (lo_seq[(base + k) % 64] != 2) begin
        n_fail++; $display("FAIL single_gap%0d got %0d want 2", k, lo_seq[(base + k) % 64]);
      end
    end
    n_checks++; if (point_count !== 4'd1) begin n_fail++; $display("FAIL single_pc got %0d want 1", point_count); end
    n_checks++; if (done_cnt - dc != 1) begin n_fail++; $display("FAIL single_done_cnt got %0d want 1", done_cnt - dc); end
    read_buf(4'd0, d);
    n_checks++; if (d !== 8'h0B) begin n_fail++; $display("FAIL single_buf0 got %0h want 0b", d); end
  endtask

  task automatic test_sweep;
    bit ok;
    logic [7:0] d;
    logic [7:0] exp_res [3] = '{8'h0B, 8'h12, 8'h1B};
    launch(8'd1, 8'd2, 8'd3, 8'd2, 4'd3);
    wait_done(120, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sweep_done got timeout want done"); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sweep_busy_drop got %b want 0", busy); end
    n_checks++; if (done_cyc - launch_cyc != 76) begin n_fail++; $display("FAIL sweep_latency got %0d want 76", done_cyc - launch_cyc); end
    n_checks++; if (point_count !== 4'd3) begin n_fail++; $display("FAIL sweep_pc got %0d want 3", point_count); end
    for (int k = 0; k < 3; k++) begin
      read_buf(4'(k), d);
      n_checks++;
      if (d !== exp_res[k]) begin n_fail++; $display("FAIL sweep_buf%0d got %0h want %0h", k, d, exp_res[k]); end
    end
  endtask

  task automatic test_wrap;
    int base;
    bit ok;
    logic [7:0] d;
    base = go_rises;
    launch(8'd1, 8'd0, 8'd5, 8'd255, 4'd2);
    wait_done(80, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_done got timeout want done"); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (seq[(base + 3) % 64] !== 8'd255) begin n_fail++; $display("FAIL wrap_x0 got %0d want 255", seq[(base + 3) % 64]); end
    n_checks++; if (seq[(base + 7) % 64] !== 8'd0) begin n_fail++; $display("FAIL wrap_x1 got %0d want 0", seq[(base + 7) % 64]); end
    read_buf(4'd0, d);
    n_checks++; if (d !== 8'h06) begin n_fail++; $display("FAIL wrap_buf0 got %0h want 06", d); end
    read_buf(4'd1, d);
    n_checks++; if (d !== 8'h05) begin n_fail++; $display("FAIL wrap_buf1 got %0h want 05", d); end
  endtask

  task automatic test_zero_points;
    int base;
    bit ok;
    base = go_rises;
    launch(8'd1, 8'd2, 8'd3, 8'd4, 4'd0);
    wait_done(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_done got timeout want done"); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (done_cyc - launch_cyc != 1) begin n_fail++; $display("FAIL zero_latency got %0d want 1", done_cyc - launch_cyc); end
    n_checks++; if (go_rises != base) begin n_fail++; $display("FAIL zero_pulses got %0d want 0", go_rises - base); end
    n_checks++; if (point_count !== 4'd0) begin n_fail++; $display("FAIL zero_pc got %0d want 0", point_count); end
  endtask

  task automatic test_start_ignored;
    int base;
    bit ok;
    base = go_rises;
    launch(8'd1, 8'd2, 8'd3, 8'd2, 4'd2);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(80, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ignore_done got timeout want done"); end
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (done_cyc - launch_cyc != 51) begin n_fail++; $display("FAIL ignore_latency got %0d want 51", done_cyc - launch_cyc); end
    n_checks++; if (go_rises - base != 8) begin n_fail++; $display("FAIL ignore_pulses got %0d want 8", go_rises - base); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_relaunch got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int k, bad;
    logic gp;
    logic [7:0] d;
    launch(8'd0, 8'd0, 8'h44, 8'd0, 4'd3);
    k = 0; gp = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (go && !gp) k++;
      gp = go;
      if (k == 7) break;
    end
    n_checks++; if (k != 7) begin n_fail++; $display("FAIL midrst_reach got %0d pulses want 7", k); end
    resetn = 1'b0;
    @(negedge clk);
    n_checks++; if (go !== 1'b0) begin n_fail++; $display("FAIL midrst_go got %b want 0", go); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_checks++; if (point_count !== 4'd0) begin n_fail++; $display("FAIL midrst_pc got %0d want 0", point_count); end
    @(posedge clk); #1;
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || go !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midrst_stays_idle got %0d bad cycles want 0", bad); end
    read_buf(4'd0, d);
    n_checks++; if (d !== 8'h44) begin n_fail++; $display("FAIL midrst_buf0 got %0h want 44", d); end
    read_buf(4'd1, d);
    n_checks++; if (d !== 8'h12) begin n_fail++; $display("FAIL midrst_buf1 got %0h want 12", d); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_wrap();
    test_zero_points();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
